// File: rtl/score_keeper_if.sv
// score_keeper_if
//   Groups the score keeper's key/score inputs and its match-state outputs.
//   master : driver of key byte and score flags, reader of match state
//   slave  : the score keeper itself
//   Signals:
//     i_key_byte    8  last received key byte (level)
//     i_p1_scored   1  point to player 1 (level)
//     i_p2_scored   1  point to player 2 (level)
//     o_p1_score    4  player 1 score
//     o_p2_score    4  player 2 score
//     o_ball_enable 1  ball may move
//     o_game_over   1  match finished
//     o_winner      2  00 none, 01 player 1, 10 player 2
//     o_point_pulse 1  one-cycle strobe per counted point
interface score_keeper_if;
  logic [7:0] i_key_byte;
  logic       i_p1_scored;
  logic       i_p2_scored;
  logic [3:0] o_p1_score;
  logic [3:0] o_p2_score;
  logic       o_ball_enable;
  logic       o_game_over;
  logic [1:0] o_winner;
  logic       o_point_pulse;

  modport master (
    output i_key_byte, i_p1_scored, i_p2_scored,
    input  o_p1_score, o_p2_score, o_ball_enable, o_game_over, o_winner, o_point_pulse
  );

  modport slave (
    input  i_key_byte, i_p1_scored, i_p2_scored,
    output o_p1_score, o_p2_score, o_ball_enable, o_game_over, o_winner, o_point_pulse
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper
//   Keeps both players' scores and runs the match FSM (IDLE, PLAY, PAUSE, OVER)
//   downstream of the ball stage. All outputs are registered.
//   Ports:
//     i_CLK  in  system (pixel) clock, rising edge
//     i_RST  in  asynchronous active-high reset
//     bus    slave side of score_keeper_if (key byte, score flags in;
//            scores, ball enable, game over, winner, point pulse out)
module score_keeper #(
  parameter int START        = 103,
  parameter int RESTART      = 98,
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 25_000_000
) (
  input  logic           i_CLK,
  input  logic           i_RST,
  score_keeper_if.slave  bus
);

  localparam int                CNT_W       = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  PAUSE_LOAD  = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [3:0]        WIN         = 4'(WIN_SCORE);
  localparam logic [7:0]        KEY_START   = 8'(START);
  localparam logic [7:0]        KEY_RESTART = 8'(RESTART);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_OVER} state_t;

  state_t           state_q, state_d;
  logic [3:0]       p1_score_q, p1_score_d;
  logic [3:0]       p2_score_q, p2_score_d;
  logic             ball_en_q, ball_en_d;
  logic             game_over_q, game_over_d;
  logic [1:0]       winner_q, winner_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p1_prev_q, p1_prev_d;
  logic             p2_prev_q, p2_prev_d;

  logic             p1_rise, p2_rise;
  logic [3:0]       p1_inc, p2_inc;

  // Saturating increment: a score never passes WIN_SCORE.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  assign p1_rise = bus.i_p1_scored & ~p1_prev_q;
  assign p2_rise = bus.i_p2_scored & ~p2_prev_q;
  assign p1_inc  = sat_inc(p1_score_q);
  assign p2_inc  = sat_inc(p2_score_q);

  always_comb begin
    state_d    = state_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    // Edge registers track the inputs in every state, so a level that was
    // already high during PAUSE does not register as a new point in PLAY.
    p1_prev_d  = bus.i_p1_scored;
    p2_prev_d  = bus.i_p2_scored;

    if (bus.i_key_byte == KEY_RESTART) begin
      state_d    = S_IDLE;
      p1_score_d = 4'd0;
      p2_score_d = 4'd0;
      winner_d   = 2'b00;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_key_byte == KEY_START) begin
            state_d    = S_PLAY;
            p1_score_d = 4'd0;
            p2_score_d = 4'd0;
          end
        end
        S_PLAY: begin
          // Simultaneous edges are treated as a tie and discarded.
          if (p1_rise ^ p2_rise) begin
            pulse_d = 1'b1;
            if (p1_rise) begin
              p1_score_d = p1_inc;
              if (p1_inc == WIN) begin
                state_d  = S_OVER;
                winner_d = 2'b01;
              end else begin
                state_d = S_PAUSE;
                cnt_d   = PAUSE_LOAD;
              end
            end else begin
              p2_score_d = p2_inc;
              if (p2_inc == WIN) begin
                state_d  = S_OVER;
                winner_d = 2'b10;
              end else begin
                state_d = S_PAUSE;
                cnt_d   = PAUSE_LOAD;
              end
            end
          end
        end
        S_PAUSE: begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_OVER: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Registered outputs follow the state being entered.
    ball_en_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      p1_score_q  <= 4'd0;
      p2_score_q  <= 4'd0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
      p1_prev_q   <= 1'b0;
      p2_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      ball_en_q   <= ball_en_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
      p1_prev_q   <= p1_prev_d;
      p2_prev_q   <= p2_prev_d;
    end
  end

  assign bus.o_p1_score    = p1_score_q;
  assign bus.o_p2_score    = p2_score_q;
  assign bus.o_ball_enable = ball_en_q;
  assign bus.o_game_over   = game_over_q;
  assign bus.o_winner      = winner_q;
  assign bus.o_point_pulse = pulse_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Directed match scenarios followed by random key/score traffic, each cycle
//   compared against a match-level reference model (WIN_SCORE=3, PAUSE_CYCLES=4).
module tb_score_keeper;

  localparam int WIN   = 3;
  localparam int PAUSE = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_keeper_if bus ();

  score_keeper #(
    .START(103), .RESTART(98), .WIN_SCORE(WIN), .PAUSE_CYCLES(PAUSE)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: match phase, scores, remaining pause clocks, winner.
  int m_mode;
  int m_score [2];
  int m_left;
  int m_winner;
  bit m_pulse;
  bit m_prev  [2];

  task automatic model_reset();
    m_mode = M_IDLE; m_score[0] = 0; m_score[1] = 0;
    m_left = 0; m_winner = 0; m_pulse = 0; m_prev[0] = 0; m_prev[1] = 0;
  endtask

  task automatic model_edge(input logic [7:0] key, input bit p1, input bit p2);
    bit r [2];
    r[0] = p1 && !m_prev[0];
    r[1] = p2 && !m_prev[1];
    m_pulse = 0;
    if (key == 8'd98) begin
      m_mode = M_IDLE; m_score[0] = 0; m_score[1] = 0; m_winner = 0; m_left = 0;
    end else if (m_mode == M_IDLE) begin
      if (key == 8'd103) begin
        m_mode = M_PLAY; m_score[0] = 0; m_score[1] = 0;
      end
    end else if (m_mode == M_PLAY) begin
      if (r[0] != r[1]) begin
        int w;
        w = r[0] ? 0 : 1;
        m_score[w] = m_score[w] + 1;
        m_pulse = 1;
        if (m_score[w] == WIN) begin
          m_mode = M_OVER; m_winner = w + 1;
        end else begin
          m_mode = M_PAUSE; m_left = PAUSE;  // clocks the ball stays held
        end
      end
    end else if (m_mode == M_PAUSE) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = M_PLAY;
    end
    m_prev[0] = p1;
    m_prev[1] = p2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".p1_score"},  32'(bus.o_p1_score),    32'(m_score[0]));
    chk({tag, ".p2_score"},  32'(bus.o_p2_score),    32'(m_score[1]));
    chk({tag, ".ball_en"},   32'(bus.o_ball_enable), 32'(m_mode == M_PLAY));
    chk({tag, ".game_over"}, 32'(bus.o_game_over),   32'(m_mode == M_OVER));
    chk({tag, ".winner"},    32'(bus.o_winner),      32'(m_winner));
    chk({tag, ".pulse"},     32'(bus.o_point_pulse), 32'(m_pulse));
  endtask

  task automatic step(input string tag, input logic [7:0] key, input bit p1, input bit p2);
    @(negedge clk);
    bus.i_key_byte  = key;
    bus.i_p1_scored = p1;
    bus.i_p2_scored = p2;
    @(posedge clk);
    model_edge(key, p1, p2);
    #1;
    check_all(tag);
  endtask

  initial begin
    int pause_len;
    int guard;
    rst = 1'b1;
    bus.i_key_byte  = 8'd0;
    bus.i_p1_scored = 1'b0;
    bus.i_p2_scored = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step("idle", 8'd0, 0, 0);
    step("start", 8'd103, 0, 0);
    chk("start.ball_en_direct", 32'(bus.o_ball_enable), 32'd1);

    // p1 held high 5 cycles with START still held: one point, pause of 4 clocks.
    step("p1_point", 8'd103, 1, 0);
    chk("p1_point.score_direct", 32'(bus.o_p1_score), 32'd1);
    chk("p1_point.pulse_direct", 32'(bus.o_point_pulse), 32'd1);
    pause_len = 1;
    for (int i = 0; i < 20; i++) begin
      step("p1_pause", 8'd103, (i < 4), 0);
      if (bus.o_ball_enable === 1'b1) break;
      pause_len++;
    end
    chk("pause_len", 32'(pause_len), 32'(PAUSE));

    // Simultaneous rising edges are discarded.
    step("pre_tie", 8'd0, 0, 0);
    step("tie", 8'd0, 1, 1);
    chk("tie.pulse_direct", 32'(bus.o_point_pulse), 32'd0);
    chk("tie.ball_en_direct", 32'(bus.o_ball_enable), 32'd1);
    step("post_tie", 8'd0, 0, 0);

    // Player 2 takes three points; a p1 edge mid-pause is ignored.
    for (int k = 0; k < WIN; k++) begin
      step("p2_point", 8'd0, 0, 1);
      guard = 0;
      while (bus.o_ball_enable !== 1'b1 && bus.o_game_over !== 1'b1 && guard < 20) begin
        step("p2_pause", 8'd0, (guard == 1), (guard == 0));
        guard++;
      end
      chk("p2_pause_bounded", 32'(guard < 20), 32'd1);
    end
    chk("win.p2_score_direct", 32'(bus.o_p2_score), 32'(WIN));
    chk("win.winner_direct", 32'(bus.o_winner), 32'd2);
    chk("win.over_direct", 32'(bus.o_game_over), 32'd1);
    step("over_p1", 8'd0, 1, 0);
    step("over_start", 8'd103, 0, 0);
    chk("over_start.winner_direct", 32'(bus.o_winner), 32'd2);

    step("restart", 8'd98, 0, 0);
    chk("restart.over_direct", 32'(bus.o_game_over), 32'd0);
    step("restart_start", 8'd103, 0, 0);
    chk("restart_start.ball_en_direct", 32'(bus.o_ball_enable), 32'd1);

    // Asynchronous reset in the middle of a pause.
    step("pre_async", 8'd0, 1, 0);
    step("in_pause", 8'd0, 0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] key;
      int r;
      r = $urandom_range(0, 99);
      key = (r < 3) ? 8'd98 : (r < 15) ? 8'd103 : 8'($urandom_range(0, 90));
      step("rand", key, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
